// File: rtl/dco_ctrl_pkg.sv
// Shared types and constants for the DCO coarse frequency-lock controller.
package dco_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_EVAL    = 2'd3
    } state_t;

    typedef enum logic {
        PH_SEARCH = 1'b0,
        PH_TRACK  = 1'b1
    } phase_t;

    localparam int               CODE_W     = 7;
    localparam int               COARSE_W   = 128;
    localparam logic [CODE_W-1:0] START_IDX = 7'd64;
    localparam logic [CODE_W-1:0] CODE_MAX  = 7'd127;
    localparam logic [5:0]        START_STEP = 6'd32;

    // Thermometer expansion: bit i is set when i < idx.
    function automatic logic [COARSE_W-1:0] thermo(input logic [CODE_W-1:0] idx);
        logic [COARSE_W-1:0] t;
        t = '0;
        for (int i = 0; i < COARSE_W; i++) begin
            t[i] = (i < int'(idx));
        end
        return t;
    endfunction

endpackage

// File: rtl/dco_edge_cnt.sv
// Feedback-clock synchronizer, rising-edge detect and saturating window counter.
module dco_edge_cnt
    import dco_ctrl_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             i_fb,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;

    assign w_rise = r_sync2 & ~r_prev;
    assign o_cnt  = r_cnt;

    // Two-flop synchronizer for the asynchronous feedback plus one history flop.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_fb;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Edge counter: clear wins over counting; sticks at all-ones.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && w_rise && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dco_freq_ctrl.sv
// DCO coarse-code frequency-lock controller: binary search then +/-1 tracking.
//
// state   | meaning
// IDLE    | disabled, code held
// SETTLE  | waiting for the DCO to settle after a code change
// MEASURE | counting feedback edges over the window
// EVAL    | latch count, update code index, lock bookkeeping
module dco_freq_ctrl
    import dco_ctrl_pkg::*;
#(
    parameter int WIN_CYC    = 256,
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 12,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic                en,
    input  logic [CNT_W-1:0]    target_cnt,
    input  logic                dco_fb,
    output logic [COARSE_W-1:0] coarse,
    output logic [CODE_W-1:0]   code_idx,
    output logic [CNT_W-1:0]    meas_cnt,
    output logic                meas_valid,
    output logic                busy,
    output logic                lock
);

    localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int LK_W    = $clog2(LOCK_CNT + 1);
    localparam int DW      = CNT_W + 1;

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'(WIN_CYC - 1);
    localparam logic [LK_W-1:0]  LOCK_TC     = LK_W'(LOCK_CNT);

    state_t                r_state;
    phase_t                r_phase;
    logic [5:0]            r_step;
    logic [CODE_W-1:0]     r_code;
    logic [COARSE_W-1:0]   r_coarse;
    logic [CNT_W-1:0]      r_meas;
    logic                  r_meas_valid;
    logic                  r_lock;
    logic [LK_W-1:0]       r_intol;
    logic [TMR_W-1:0]      r_timer;

    logic [CNT_W-1:0]      w_cnt;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;
    logic signed [DW-1:0]  w_diff;
    logic [DW-1:0]         w_abs;
    logic                  w_in_tol;
    logic                  w_lt;
    logic                  w_gt;
    logic                  w_move;
    logic [7:0]            w_mag;
    logic [7:0]            w_up;
    logic [CODE_W-1:0]     w_up_clamp;
    logic [CODE_W-1:0]     w_dn_clamp;
    logic [CODE_W-1:0]     w_next;
    logic [LK_W-1:0]       w_intol_inc;

    dco_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk    (clk),
        .reset_ (reset_),
        .i_fb   (dco_fb),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_cnt  (w_cnt)
    );

    // Counter is zeroed on the last settle cycle so the window starts clean.
    assign w_cnt_clr = (r_state == ST_SETTLE) && (r_timer == '0);
    assign w_cnt_en  = (r_state == ST_MEASURE);

    // Signed error; negative means the DCO is too slow.
    assign w_diff   = $signed({1'b0, w_cnt}) - $signed({1'b0, target_cnt});
    assign w_abs    = w_diff[DW-1] ? DW'(-w_diff) : DW'(w_diff);
    assign w_in_tol = (w_abs <= DW'(TOL));
    assign w_lt     = w_diff[DW-1];
    assign w_gt     = !w_diff[DW-1] && (w_diff != '0);

    // Step size and clamped up/down candidates for the next code index.
    assign w_mag      = (r_phase == PH_SEARCH) ? {2'b00, r_step} : 8'd1;
    assign w_up       = {1'b0, r_code} + w_mag;
    assign w_up_clamp = (w_up > {1'b0, CODE_MAX}) ? CODE_MAX : w_up[CODE_W-1:0];
    assign w_dn_clamp = (w_mag > {1'b0, r_code}) ? '0 : (r_code - w_mag[CODE_W-1:0]);
    assign w_move     = (r_phase == PH_SEARCH) ? 1'b1 : !w_in_tol;

    assign w_intol_inc = (r_intol == LOCK_TC) ? r_intol : (r_intol + 1'b1);

    // Next code index selected by error sign.
    always_comb begin
        w_next = r_code;
        if (w_move) begin
            if (w_lt) begin
                w_next = w_up_clamp;
            end else if (w_gt) begin
                w_next = w_dn_clamp;
            end
        end
    end

    // Main sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state      <= ST_IDLE;
            r_phase      <= PH_SEARCH;
            r_step       <= '0;
            r_code       <= '0;
            r_coarse     <= '0;
            r_meas       <= '0;
            r_meas_valid <= 1'b0;
            r_lock       <= 1'b0;
            r_intol      <= '0;
            r_timer      <= '0;
        end else begin
            r_meas_valid <= 1'b0;
            if (!en) begin
                r_state <= ST_IDLE;
                r_lock  <= 1'b0;
                r_intol <= '0;
                r_timer <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_code   <= START_IDX;
                        r_coarse <= thermo(START_IDX);
                        r_step   <= START_STEP;
                        r_phase  <= PH_SEARCH;
                        r_intol  <= '0;
                        r_lock   <= 1'b0;
                        r_timer  <= SETTLE_LOAD;
                        r_state  <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (r_timer == '0) begin
                            r_timer <= WIN_LOAD;
                            r_state <= ST_MEASURE;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (r_timer == '0) begin
                            r_state <= ST_EVAL;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    ST_EVAL: begin
                        r_meas       <= w_cnt;
                        r_meas_valid <= 1'b1;
                        r_code       <= w_next;
                        r_coarse     <= thermo(w_next);
                        if (r_phase == PH_SEARCH) begin
                            if (r_step == 6'd1) begin
                                r_phase <= PH_TRACK;
                            end else begin
                                r_step <= r_step >> 1;
                            end
                        end else if (w_in_tol) begin
                            r_intol <= w_intol_inc;
                            r_lock  <= (w_intol_inc == LOCK_TC);
                        end else begin
                            r_intol <= '0;
                            r_lock  <= 1'b0;
                        end
                        r_timer <= SETTLE_LOAD;
                        r_state <= ST_SETTLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign coarse     = r_coarse;
    assign code_idx   = r_code;
    assign meas_cnt   = r_meas;
    assign meas_valid = r_meas_valid;
    assign busy       = (r_state != ST_IDLE);
    assign lock       = r_lock;

endmodule

// File: tb/tb_dco_freq_ctrl.sv
// Scoreboard bench for dco_freq_ctrl with a phase-accumulator DCO model.
module tb_dco_freq_ctrl;

    logic         clk;
    logic         reset_;
    logic         en;
    logic [11:0]  target_cnt;
    logic         dco_fb;
    logic [127:0] coarse;
    logic [6:0]   code_idx;
    logic [11:0]  meas_cnt;
    logic         meas_valid;
    logic         busy;
    logic         lock;

    logic         en2;
    logic [5:0]   target2;
    logic         dco_fb2;
    logic [127:0] coarse2;
    logic [6:0]   code2;
    logic [5:0]   meas2;
    logic         mv2;
    logic         busy2;
    logic         lock2;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;
    int n_pop2 = 0;
    int fb_offset = 0;

    typedef struct packed {
        logic [11:0] cnt;
        logic [6:0]  idx;
        logic        lck;
    } exp_t;

    exp_t       q[$];
    logic [5:0] q2[$];

    dco_freq_ctrl u_dut (
        .clk        (clk),
        .reset_     (reset_),
        .en         (en),
        .target_cnt (target_cnt),
        .dco_fb     (dco_fb),
        .coarse     (coarse),
        .code_idx   (code_idx),
        .meas_cnt   (meas_cnt),
        .meas_valid (meas_valid),
        .busy       (busy),
        .lock       (lock)
    );

    dco_freq_ctrl #(.CNT_W(6)) u_dut_sat (
        .clk        (clk),
        .reset_     (reset_),
        .en         (en2),
        .target_cnt (target2),
        .dco_fb     (dco_fb2),
        .coarse     (coarse2),
        .code_idx   (code2),
        .meas_cnt   (meas2),
        .meas_valid (mv2),
        .busy       (busy2),
        .lock       (lock2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] th(input int n);
        logic [127:0] one;
        one = 128'd1;
        if (n >= 128) return '1;
        return (one << n) - 1;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int c, input int i, input int l);
        exp_t e;
        e.cnt = 12'(c);
        e.idx = 7'(i);
        e.lck = 1'(l);
        q.push_back(e);
    endtask

    task automatic wait_pops(input int n);
        int budget;
        int c;
        budget = (n - n_pop) * 300 + 100;
        c = 0;
        while (n_pop < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (n_pop < n) begin
            errors++;
            $display("FAIL wait_meas_valid got %0d records want %0d", n_pop, n);
        end
    endtask

    // DCO model: frequency follows the coarse code; a carry out of an 8-bit
    // accumulator gives exactly N pulses in any 256 consecutive cycles.
    initial begin
        logic [7:0] acc;
        logic [8:0] sum;
        int         n;
        acc = '0;
        dco_fb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            n = $countones(coarse) + fb_offset;
            sum = {1'b0, acc} + 9'(n);
            dco_fb = sum[8];
            acc = sum[7:0];
        end
    end

    // Feedback at clk/3 for the narrow-counter instance.
    initial begin
        int ph;
        ph = 0;
        dco_fb2 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph == 2) ? 0 : ph + 1;
            dco_fb2 = (ph == 0);
        end
    end

    // Monitor for the main instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_ && meas_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_meas_valid got meas_cnt=%0d code_idx=%0d want no pulse", meas_cnt, code_idx);
                end else begin
                    e = q.pop_front();
                    chk("meas_cnt", meas_cnt, e.cnt);
                    chk("code_idx", code_idx, e.idx);
                    chk("lock", lock, e.lck);
                    chk("coarse", coarse, th(int'(e.idx)));
                    n_pop++;
                end
            end
        end
    end

    // Monitor for the saturation instance.
    initial begin
        logic [5:0] e2;
        forever begin
            @(negedge clk);
            if (reset_ && mv2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_meas_valid_sat got %0d want no pulse", meas2);
                end else begin
                    e2 = q2.pop_front();
                    chk("sat_meas_cnt", meas2, e2);
                    n_pop2++;
                end
            end
        end
    end

    // Saturation instance stimulus.
    initial begin
        int c;
        en2 = 1'b0;
        target2 = 6'd63;
        @(posedge reset_);
        @(posedge clk);
        #1;
        q2.push_back(6'd63);
        q2.push_back(6'd63);
        en2 = 1'b1;
        c = 0;
        while (n_pop2 < 2 && c < 700) begin
            @(posedge clk);
            c++;
        end
        checks++;
        if (n_pop2 < 2) begin
            errors++;
            $display("FAIL wait_sat_valid got %0d want 2", n_pop2);
        end
        #1;
        en2 = 1'b0;
    end

    // Main stimulus.
    initial begin
        int n;
        logic got;
        reset_ = 1'b0;
        en = 1'b0;
        target_cnt = 12'd93;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_coarse", coarse, 128'd0);
        chk("rst_code_idx", code_idx, 7'd0);
        chk("rst_meas_cnt", meas_cnt, 12'd0);
        chk("rst_meas_valid", meas_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lock", lock, 1'b0);

        // Search to 93, then four in-tolerance track evaluations.
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        push(64, 96, 0); push(96, 80, 0); push(80, 88, 0);
        push(88, 92, 0); push(92, 94, 0); push(94, 93, 0);
        push(93, 93, 0); push(93, 93, 0); push(93, 93, 0); push(93, 93, 1);
        en = 1'b1;
        wait_pops(10);
        chk("lock_at_93", lock, 1'b1);
        chk("coarse_93", coarse, 128'h00000000_1FFFFFFF_FFFFFFFF_FFFFFFFF);

        // Drift: DCO runs 5 counts fast.
        fb_offset = 5;
        push(98, 92, 0); push(97, 91, 0); push(96, 90, 0); push(95, 89, 0);
        push(94, 89, 0); push(94, 89, 0); push(94, 89, 0); push(94, 89, 1);
        wait_pops(18);

        // Enable drop mid-window.
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_window", busy, 1'b1);
        chk("lock_mid_window", lock, 1'b1);
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drop_busy", busy, 1'b0);
        chk("drop_lock", lock, 1'b0);
        chk("drop_code_idx", code_idx, 7'd89);
        chk("drop_coarse", coarse, th(89));
        repeat (20) @(posedge clk);

        // Restart: search from 64, first result 266 cycles after enable.
        fb_offset = 0;
        push(64, 96, 0); push(96, 80, 0); push(80, 88, 0);
        push(88, 92, 0); push(92, 94, 0); push(94, 93, 0);
        push(93, 93, 0); push(93, 93, 0); push(93, 93, 0); push(93, 93, 1);
        @(posedge clk);
        #1;
        en = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) chk("restart_code_idx", code_idx, 7'd64);
            if (meas_valid) got = 1'b1;
        end
        chk("first_valid_latency", n, 266);
        wait_pops(28);

        // Target out of reach: code pins at the top.
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        target_cnt = 12'd4000;
        push(64, 96, 0); push(96, 112, 0); push(112, 120, 0);
        push(120, 124, 0); push(124, 126, 0); push(126, 127, 0);
        push(127, 127, 0); push(127, 127, 0); push(127, 127, 0);
        #1;
        en = 1'b1;
        wait_pops(37);
        chk("sat_high_coarse", coarse, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        chk("sat_high_lock", lock, 1'b0);

        // Asynchronous reset in the middle of the window at code 80.
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        target_cnt = 12'd93;
        push(64, 96, 0); push(96, 80, 0);
        #1;
        en = 1'b1;
        wait_pops(39);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_code_idx", code_idx, 7'd80);
        chk("pre_reset_busy", busy, 1'b1);
        #2;
        reset_ = 1'b0;
        #1;
        chk("arst_coarse", coarse, 128'd0);
        chk("arst_code_idx", code_idx, 7'd0);
        chk("arst_lock", lock, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_meas_valid", meas_valid, 1'b0);
        q.delete();
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
